// File: rtl/sync_seq_pkg.sv
// Shared types and constants for the synchronizer test sequencer.
// Building with SYNC_SEQ_LFSR_EN selects the LFSR pattern instead of the incrementing one.
package sync_seq_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_CHECK    = 3'd2,
        ST_WAIT_LOW = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [7:0]       LFSR_MASK = 8'hB8;
    localparam logic [CNT_W-1:0] SAT_MAX   = 8'd255;

    // Increment that sticks at SAT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == SAT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_seq_pattern.sv
// Pattern generator: the first word of a run and the word that follows the current one.
// SYNC_SEQ_LFSR_EN selects a Galois LFSR; otherwise the pattern increments.
module sync_seq_pattern
    import sync_seq_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] cur,
    input  logic [N-1:0] seed,
    output logic [N-1:0] next_c,
    output logic [N-1:0] first_c
);

`ifdef SYNC_SEQ_LFSR_EN
    localparam logic [N-1:0] MASK = N'(LFSR_MASK);

    // An all-zero LFSR state would lock up, so a zero seed becomes 1.
    always_comb begin
        next_c  = (cur >> 1) ^ (cur[0] ? MASK : '0);
        first_c = (seed == '0) ? N'(1) : seed;
    end
`else
    always_comb begin
        next_c  = cur + N'(1);
        first_c = seed;
    end
`endif

endmodule

// File: rtl/sync_seq_ctrl.sv
// Test sequencer: drives one synchronizer channel via four-phase req/ack and scores the returned words.
// Pattern type is chosen by SYNC_SEQ_LFSR_EN (see sync_seq_pattern).
module sync_seq_ctrl
    import sync_seq_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned TIMEOUT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [2:0]       sel_in,
    input  logic [N-1:0]     seed,
    input  logic [7:0]       num_xfers,
    input  logic             ack_async,
    input  logic [N-1:0]     rx_data,
    output logic             req,
    output logic [N-1:0]     tx_data,
    output logic [2:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [7:0]       pass_cnt,
    output logic [7:0]       fail_cnt,
    output logic             timeout
);

    // Last counter value before a wait is abandoned: each wait state lasts 2^W-1 cycles.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

    state_t               state, state_nxt;
    logic                 ack_meta, ack_s;
    logic [TIMEOUT_W-1:0] tcnt, tcnt_nxt;
    logic [7:0]           xfer, xfer_nxt;
    logic                 req_nxt, busy_nxt, done_nxt, to_nxt;
    logic [N-1:0]         tx_nxt, pat_next_c, pat_first_c;
    logic [2:0]           sel_nxt;
    logic [7:0]           pass_nxt, fail_nxt;

    sync_seq_pattern #(.N(N)) u_pattern (
        .cur     (tx_data),
        .seed    (seed),
        .next_c  (pat_next_c),
        .first_c (pat_first_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt + TIMEOUT_W'(1);
        xfer_nxt  = xfer;
        req_nxt   = req;
        tx_nxt    = tx_data;
        sel_nxt   = sel;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        pass_nxt  = pass_cnt;
        fail_nxt  = fail_cnt;
        to_nxt    = timeout;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    pass_nxt = '0;
                    fail_nxt = '0;
                    to_nxt   = 1'b0;
                    xfer_nxt = '0;
                    busy_nxt = 1'b1;
                    if (num_xfers != 8'd0) begin
                        sel_nxt   = sel_in;
                        tx_nxt    = pat_first_c;
                        req_nxt   = 1'b1;
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_nxt = ST_CHECK;
                end else if (tcnt == TO_LAST) begin
                    fail_nxt  = sat_inc(fail_cnt);
                    to_nxt    = 1'b1;
                    req_nxt   = 1'b0;
                    state_nxt = ST_WAIT_LOW;
                end
            end
            ST_CHECK: begin
                if (rx_data == tx_data) pass_nxt = sat_inc(pass_cnt);
                else                    fail_nxt = sat_inc(fail_cnt);
                req_nxt   = 1'b0;
                state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!ack_s) begin
                    if (xfer == 8'(num_xfers - 8'd1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        xfer_nxt  = xfer + 8'd1;
                        tx_nxt    = pat_next_c;
                        req_nxt   = 1'b1;
                        state_nxt = ST_REQ;
                    end
                end else if (tcnt == TO_LAST) begin
                    // Far side never released ack: abandon the rest of the run.
                    to_nxt    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (state_nxt != state || state == ST_IDLE) tcnt_nxt = '0;
    end

    // Synchronizer samples every cycle; everything else is frozen while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
            state    <= ST_IDLE;
            tcnt     <= '0;
            xfer     <= '0;
            req      <= 1'b0;
            tx_data  <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            ack_meta <= ack_async;
            ack_s    <= ack_meta;
            if (ena) begin
                state    <= state_nxt;
                tcnt     <= tcnt_nxt;
                xfer     <= xfer_nxt;
                req      <= req_nxt;
                tx_data  <= tx_nxt;
                sel      <= sel_nxt;
                busy     <= busy_nxt;
                done     <= done_nxt;
                pass_cnt <= pass_nxt;
                fail_cnt <= fail_nxt;
                timeout  <= to_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sync_seq_ctrl.sv
// Scoreboard bench for sync_seq_ctrl: a behavioural far-end model plus queued expectations
// checked by an independent monitor on req rises and done pulses.
module tb_sync_seq_ctrl;

    localparam int M_LOOP   = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_STUCK1 = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic [2:0] sel_in = 3'd0;
    logic [7:0] seed = 8'd0;
    logic [7:0] num_xfers = 8'd0;
    logic       ack_async;
    logic [7:0] rx_data;
    logic       req;
    logic [7:0] tx_data;
    logic [2:0] sel;
    logic       busy;
    logic       done;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;
    logic       timeout;

    int         mode = M_LOOP;
    logic [7:0] corrupt = 8'h00;

    // Far-end model: loopback, ack stuck low, or ack stuck high; returned word optionally corrupted.
    assign ack_async = (mode == M_STUCK1) ? 1'b1 : ((mode == M_LOOP) ? req : 1'b0);
    assign rx_data   = tx_data ^ corrupt;

    sync_seq_ctrl #(.N(8), .TIMEOUT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .sel_in    (sel_in),
        .seed      (seed),
        .num_xfers (num_xfers),
        .ack_async (ack_async),
        .rx_data   (rx_data),
        .req       (req),
        .tx_data   (tx_data),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .timeout   (timeout)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        int         len;
    } xfer_exp_t;

    typedef struct {
        int         pass;
        int         fail;
        int         to;
        int         busy_len;
        logic [2:0] sel;
    } run_exp_t;

    xfer_exp_t xq[$];
    run_exp_t  rq[$];

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0;
    int done_cnt = 0;
    logic [2:0] sel_model = 3'd0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // i-th word of a run, straight from the pattern rule.
    function automatic logic [7:0] pattern_word(input logic [7:0] s, input int i);
        logic [7:0] v;
`ifdef SYNC_SEQ_LFSR_EN
        v = (s == 8'h00) ? 8'h01 : s;
        for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
`else
        v = 8'((int'(s) + i) % 256);
`endif
        return v;
    endfunction

    // Expected outcome of one run under a given far-end behaviour.
    task automatic push_expect(input logic [7:0] s, input int n, input int m,
                               input logic [7:0] cor, input logic [2:0] sl, input int freeze);
        run_exp_t r;
        xfer_exp_t x;
        r.pass = 0; r.fail = 0; r.to = 0;
        if (n != 0) sel_model = sl;
        r.sel = sel_model;
        if (n == 0) begin
            r.busy_len = 1;
        end else if (m == M_LOOP) begin
            for (int i = 0; i < n; i++) begin
                x.word = pattern_word(s, i); x.len = 4; xq.push_back(x);
            end
            r.pass = (cor == 8'h00) ? sat(n) : 0;
            r.fail = (cor == 8'h00) ? 0 : sat(n);
            r.busy_len = 7 * n + 1 + freeze;
        end else if (m == M_STUCK0) begin
            for (int i = 0; i < n; i++) begin
                x.word = pattern_word(s, i); x.len = 63 + ((i == 0) ? freeze : 0); xq.push_back(x);
            end
            r.fail = sat(n); r.to = 1;
            r.busy_len = 64 * n + 1 + freeze;
        end else begin
            x.word = pattern_word(s, 0); x.len = 2; xq.push_back(x);
            r.pass = (cor == 8'h00) ? 1 : 0;
            r.fail = (cor == 8'h00) ? 0 : 1;
            r.to = 1;
            r.busy_len = 66;
        end
        rq.push_back(r);
    endtask

    // Monitor: compare on each req rise, req fall and done pulse.
    logic      req_q = 1'b0, busy_q = 1'b0, done_q = 1'b0, have_x = 1'b0;
    int        req_len = 0, busy_len = 0;
    xfer_exp_t cur_x;
    run_exp_t  cur_r;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_q = 1'b0; busy_q = 1'b0; done_q = 1'b0; have_x = 1'b0;
            end else begin
                if (req && !req_q) begin
                    rise_cnt++;
                    req_len = 1;
                    if (xq.size() == 0) begin
                        have_x = 1'b0;
                        check("unexpected_req", 1, 0);
                    end else begin
                        cur_x = xq.pop_front();
                        have_x = 1'b1;
                        check("tx_data", int'(tx_data), int'(cur_x.word));
                    end
                end else if (req) begin
                    req_len++;
                end
                if (!req && req_q && have_x) check("req_len", req_len, cur_x.len);

                if (busy && !busy_q) busy_len = 1;
                else if (busy) busy_len++;

                if (done) begin
                    if (done_q) begin
                        check("done_width", 2, 1);
                    end else begin
                        done_cnt++;
                        if (rq.size() == 0) begin
                            check("unexpected_done", 1, 0);
                        end else begin
                            cur_r = rq.pop_front();
                            check("pass_cnt", int'(pass_cnt), cur_r.pass);
                            check("fail_cnt", int'(fail_cnt), cur_r.fail);
                            check("timeout", int'(timeout), cur_r.to);
                            check("busy_len", busy_len, cur_r.busy_len);
                            check("sel", int'(sel), int'(cur_r.sel));
                            check("xfers_left", xq.size(), 0);
                        end
                    end
                end
                req_q = req; busy_q = busy; done_q = done;
            end
        end
    end

    task automatic do_start(input logic [7:0] s, input int n, input logic [2:0] sl);
        @(posedge clk); #1;
        seed = s; num_xfers = 8'(n); sel_in = sl; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == base) check("done_wait", 0, 1);
        repeat (4) @(posedge clk);
    endtask

    task automatic run_one(input logic [7:0] s, input int n, input int m,
                           input logic [7:0] cor, input logic [2:0] sl, input int freeze);
        int base;
        @(posedge clk); #1;
        mode = m; corrupt = cor;
        repeat (3) @(posedge clk);
        push_expect(s, n, m, cor, sl, freeze);
        base = done_cnt;
        do_start(s, n, sl);
        if (freeze != 0) begin
            repeat (5) @(posedge clk);
            #1 ena = 1'b0;
            repeat (freeze / 2) @(posedge clk);
            #1;
            check("freeze_req", int'(req), 1);
            check("freeze_busy", int'(busy), 1);
            repeat (freeze - freeze / 2 - 1) @(posedge clk);
            @(posedge clk); #1 ena = 1'b1;
        end
        wait_done(base, 70 * n + 200 + freeze);
    endtask

    initial begin
        int         m, n, target, k;
        logic [7:0] c;
        xfer_exp_t  x;
        logic [7:0] s;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req", int'(req), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass_cnt), 0);
        check("rst_fail", int'(fail_cnt), 0);
        check("rst_timeout", int'(timeout), 0);
        @(posedge clk); #2 rst_n = 1'b1;

        run_one(8'h05, 3, M_LOOP, 8'h00, 3'd2, 0);
        run_one(8'h3C, 4, M_LOOP, 8'h01, 3'd5, 0);
        run_one(8'hA0, 2, M_STUCK0, 8'h00, 3'd1, 0);
        run_one(8'h11, 0, M_LOOP, 8'h00, 3'd7, 0);
        run_one(8'h00, 3, M_LOOP, 8'h00, 3'd3, 0);
        run_one(8'h7E, 3, M_STUCK1, 8'h00, 3'd6, 0);
        run_one(8'h42, 1, M_STUCK0, 8'h00, 3'd4, 10);

        // Asynchronous reset while transfer 2 is waiting in REQ.
        @(posedge clk); #1;
        mode = M_LOOP; corrupt = 8'h00;
        repeat (3) @(posedge clk);
        s = 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            x.word = pattern_word(s, i); x.len = 4; xq.push_back(x);
        end
        target = rise_cnt + 2;
        do_start(s, 4, 3'd3);
        k = 0;
        while (rise_cnt < target && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("reset_reach_xfer2", rise_cnt, target);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("midrst_req", int'(req), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_pass", int'(pass_cnt), 0);
        check("midrst_fail", int'(fail_cnt), 0);
        sel_model = 3'd0;
        @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        xq.delete();

        run_one(8'($urandom), 5, M_LOOP, 8'h00, 3'd1, 0);
        run_one(8'($urandom), 255, M_LOOP, 8'h00, 3'd2, 0);

        for (int r = 0; r < 12; r++) begin
            m = int'($urandom_range(2, 0));
            n = (m == M_STUCK0) ? int'($urandom_range(3, 0)) : int'($urandom_range(10, 0));
            c = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(255, 1)) : 8'h00;
            run_one(8'($urandom), n, m, c, 3'($urandom), 0);
        end

        check("runs_left", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sync_seq_ctrl.md
# sync_seq_ctrl

Single-clock test sequencer for the clock-domain-crossing demonstrator. It generates a data pattern, drives one synchronizer channel through a four-phase req/ack handshake, and checks the returned word. Pass, fail and timeout results are accumulated so a bench or the chip pins can measure each synchronizer (2FF, pulse, toggle) without manual strobing. It sits in the `clk` domain in front of the `data_in` register. It takes the far-domain acknowledge as a raw asynchronous input.

## Interface
Parameters:
- `N`, 8: data and pattern width.
- `TIMEOUT_W`, 6: width of the handshake timeout counter. Timeout fires after 2^TIMEOUT_W−1 cycles.

Ports:
- `clk` in 1: single clock. All state is on `posedge clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: when low, FSM, counters and outputs hold their values.
- `start` in 1: level-sampled. Begins a run when the FSM is in IDLE; ignored otherwise.
- `sel_in` in 3: channel to test. Latched at start.
- `seed` in N: first pattern word.
- `num_xfers` in 8: transfers per run. 0 means an empty run.
- `ack_async` in 1: far-domain acknowledge. Asynchronous to `clk`.
- `rx_data` in N: far-domain returned word. Guaranteed stable while `ack_async` is high.
- `req` out 1: four-phase request level.
- `tx_data` out N: word under test. Stable while `req` is high.
- `sel` out 3: latched channel select. Drives the output mux.
- `busy` out 1: high from the cycle after start until DONE ends.
- `done` out 1: one-cycle pulse at the end of a run.
- `pass_cnt` out 8: count of matching transfers in the current run.
- `fail_cnt` out 8: count of mismatches plus timeouts in the current run.
- `timeout` out 1: sticky; cleared at start.

## Operation
- `ack_async` passes through an internal 2-FF synchronizer to produce `ack_s`. No other input is synchronized.
- States: IDLE, REQ, CHECK, WAIT_LOW, DONE.
- IDLE, with `start`=1 and `num_xfers`≠0: clear `pass_cnt`, `fail_cnt`, `timeout` and the transfer counter. Latch `sel_in` into `sel`. Load `tx_data`←`seed`. Set `req`=1. Go to REQ.
- IDLE, with `start`=1 and `num_xfers`=0: clear the counters, then go straight to DONE.
- REQ:
  - `ack_s`=1 → CHECK.
  - Timeout counter reaches max → `fail_cnt`+1, `timeout`=1, `req`=0, go to WAIT_LOW.
- CHECK (one cycle):
  - `rx_data`==`tx_data` → `pass_cnt`+1; otherwise `fail_cnt`+1.
  - `req`=0. Go to WAIT_LOW.
- WAIT_LOW, on `ack_s`=0:
  - If the transfer counter equals `num_xfers`−1 → DONE.
  - Otherwise increment the transfer counter, advance the pattern, set `req`=1 and go to REQ.
- WAIT_LOW timeout (ack stuck high) → `timeout`=1, then abort to DONE.
- The timeout counter clears on every state entry.
- DONE: `done`=1 for one cycle, `busy`=0, go to IDLE.
- `pass_cnt` and `fail_cnt` saturate at 255 and do not wrap.
- Counters and `sel` keep their values in IDLE so software can read them after a run.
- Reset values: `req`=0, `tx_data`=0, `sel`=0, `busy`=0, `done`=0, both counts 0, `timeout`=0, synchronizer flops 0, state IDLE.
- Reset mid-run drops `req` immediately (asynchronous) and abandons the run.

## Timing
- start sampled at cycle 0 → `req`=1, `busy`=1 at cycle 1.
- `ack_s` lags `ack_async` by 2 cycles.
- In loopback (`ack_async`=`req`, `rx_data`=`tx_data`):
  - REQ is held for 3 cycles.
  - CHECK follows at cycle 4.
  - WAIT_LOW lasts 3 cycles.
  - The next `req` rises at cycle 8.
  - Each transfer therefore takes 7 cycles.
- `done` rises one cycle after the final WAIT_LOW exit.
- `ena`=0 freezes the FSM and timeout counter. The synchronizer flops keep sampling.

## Configuration
- `SYNC_SEQ_LFSR_EN` defined: the pattern advances as a Galois LFSR.
  - Right shift; XOR with mask 0xB8 when the shifted-out bit is 1 (N=8).
  - A seed of 0 is replaced by 1.
- `SYNC_SEQ_LFSR_EN` undefined: the pattern advances as `tx_data`+1 modulo 2^N. A seed of 0 is used as-is.

## Structure
- Package `sync_seq_pkg` holds:
  - the state encoding constants;
  - the LFSR mask constant;
  - the saturation limit of 255.
- Sub-module `sync_seq_pattern` holds the pattern next-value logic, including the macro-selected LFSR or increment. The FSM, synchronizer and counters live in the top level.

## Test plan
- Loopback, `seed`=0x05, `num_xfers`=3, increment mode → `tx_data` sequence 0x05, 0x06, 0x07; `pass_cnt`=3, `fail_cnt`=0; `done` pulses once; `busy` is high for exactly 22 cycles.
- Loopback with `rx_data` bit 0 forced inverted, `num_xfers`=4 → `pass_cnt`=0, `fail_cnt`=4, `timeout`=0.
- `ack_async` tied to 0, `num_xfers`=2 → each REQ ends after 63 cycles; `fail_cnt`=2, `timeout`=1, `req` is never high in CHECK.
- `rst_n` pulsed low while in REQ during transfer 2 → `req`, `busy` and both counts are 0 at once; a new `start` runs cleanly.
- `num_xfers`=0 → `done` pulses 2 cycles after start, and `req` never rises.
- LFSR build, `seed`=0x00, `num_xfers`=3 → `tx_data` sequence 0x01, 0xB8, 0x5C; `num_xfers`=255 → `pass_cnt`=255 with no wrap.
